// File: rtl/risc_control_fsm.sv
// risc_control_fsm: multicycle controller for the Simple RISC Machine.
// Each instruction passes through fetch, decode, execute and writeback.
// The controller drives the decoder's nsel, every datapath load/select strobe,
// the PC/IR controls and the memory command.
//
// Optional feature: define RISC_CTRL_IRQ_EN to enable the level-input
// interrupt. A rising edge of irq latches a pending request. The request is
// taken at the next instruction boundary through IRQ_SAVE and IRQ_VEC.
// With the macro undefined, irq is ignored and irq_ack and load_vec stay 0.
//
// Ports:
//   clk, reset         rising-edge clock; synchronous active-high reset
//   opcode, op         instruction bits 15:13 and 12:11 from the decoder
//   irq                level interrupt request (RISC_CTRL_IRQ_EN only)
//   nsel, vsel, write  register file select, writeback source, write enable
//   loada..loads       datapath A/B/C/status loads; asel/bsel operand selects
//   load_ir, load_pc   IR and PC loads; reset_pc/load_vec select the PC source
//   addr_sel,load_addr memory address source and data-address register load
//   mem_cmd            MNONE/MREAD/MWRITE
//   halted, irq_ack    HALT indicator; one-cycle interrupt acknowledge
module risc_control_fsm #(
  parameter int unsigned STATE_W = 5,
  parameter logic [1:0]  MNONE   = 2'b00,
  parameter logic [1:0]  MREAD   = 2'b01,
  parameter logic [1:0]  MWRITE  = 2'b10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  input  logic       irq,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       load_ir,
  output logic       load_pc,
  output logic       reset_pc,
  output logic       load_vec,
  output logic       addr_sel,
  output logic       load_addr,
  output logic [1:0] mem_cmd,
  output logic       halted,
  output logic       irq_ack
);

  typedef enum logic [STATE_W-1:0] {
    StRst, StIf1, StIf2, StUpdatePc, StDecode, StMovImm, StGetA, StGetB, StAluOp,
    StWriteRd, StAddrCalc, StLoadAddr, StMemRd, StLdrWb, StStrGetd, StStrPass,
    StMemWr, StHalt
`ifdef RISC_CTRL_IRQ_EN
    , StIrqSave, StIrqVec
`endif
  } state_e;

  state_e state_q, state_d;
  state_e fetch_st;  // where an instruction boundary actually goes

  logic [4:0] instr;
  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_ldr, is_str, is_halt;

  assign instr      = {opcode, op};
  assign is_mov_imm = (instr == 5'b110_10);
  assign is_mov_reg = (instr == 5'b110_00);
  assign is_alu     = (opcode == 3'b101);
  assign is_cmp     = (instr == 5'b101_01);
  assign is_ldr     = (instr == 5'b011_00);
  assign is_str     = (instr == 5'b100_00);
  assign is_halt    = (opcode == 3'b111);

`ifdef RISC_CTRL_IRQ_EN
  logic irq_prev_q, pending_q, pending_d, irq_edge;

  assign irq_edge = irq & ~irq_prev_q;
  // IRQ_SAVE consumes the request, but an edge arriving that same cycle is kept.
  assign pending_d = (state_q == StIrqSave) ? irq_edge : (pending_q | irq_edge);
  assign fetch_st  = pending_q ? StIrqSave : StIf1;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq;
      pending_q  <= pending_d;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = irq;
  assign fetch_st   = StIf1;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= StRst;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    nsel      = 2'b00;
    vsel      = 2'b00;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_vec  = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = MNONE;
    halted    = 1'b0;
    irq_ack   = 1'b0;

    case (state_q)
      StRst: begin
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        state_d  = StIf1;
      end
      StIf1: begin
        addr_sel = 1'b1;
        mem_cmd  = MREAD;
        state_d  = StIf2;
      end
      StIf2: begin
        addr_sel = 1'b1;
        mem_cmd  = MREAD;
        load_ir  = 1'b1;
        state_d  = StUpdatePc;
      end
      StUpdatePc: begin
        load_pc = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        if (is_mov_imm)                           state_d = StMovImm;
        else if (is_mov_reg)                      state_d = StGetB;
        else if (is_alu || is_ldr || is_str)      state_d = StGetA;
        else if (is_halt)                         state_d = StHalt;
        else                                      state_d = fetch_st;  // NOP
      end
      StMovImm: begin
        vsel    = 2'b01;
        write   = 1'b1;
        state_d = fetch_st;
      end
      StGetA: begin
        loada   = 1'b1;
        state_d = is_alu ? StGetB : StAddrCalc;
      end
      StGetB: begin
        nsel    = 2'b10;
        loadb   = 1'b1;
        state_d = StAluOp;
      end
      StAluOp: begin
        // The IR is stable here, so the instruction bits qualify the strobes.
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = fetch_st;
        end else begin
          asel    = is_mov_reg;
          loadc   = 1'b1;
          state_d = StWriteRd;
        end
      end
      StWriteRd: begin
        nsel    = 2'b01;
        vsel    = 2'b11;
        write   = 1'b1;
        state_d = fetch_st;
      end
      StAddrCalc: begin
        bsel    = 1'b1;
        loadc   = 1'b1;
        state_d = StLoadAddr;
      end
      StLoadAddr: begin
        load_addr = 1'b1;
        state_d   = is_ldr ? StMemRd : StStrGetd;
      end
      StMemRd: begin
        mem_cmd = MREAD;
        state_d = StLdrWb;
      end
      StLdrWb: begin
        mem_cmd = MREAD;
        nsel    = 2'b01;
        write   = 1'b1;
        state_d = fetch_st;
      end
      StStrGetd: begin
        nsel    = 2'b01;
        loadb   = 1'b1;
        state_d = StStrPass;
      end
      StStrPass: begin
        asel    = 1'b1;
        loadc   = 1'b1;
        state_d = StMemWr;
      end
      StMemWr: begin
        mem_cmd = MWRITE;
        state_d = fetch_st;
      end
      StHalt: begin
        halted  = 1'b1;
        state_d = StHalt;
      end
`ifdef RISC_CTRL_IRQ_EN
      StIrqSave: begin
        nsel    = 2'b11;
        vsel    = 2'b10;
        write   = 1'b1;
        irq_ack = 1'b1;
        state_d = StIrqVec;
      end
      StIrqVec: begin
        load_pc  = 1'b1;
        load_vec = 1'b1;
        // The handler's first instruction is always fetched before another
        // request is taken.
        state_d  = StIf1;
      end
`endif
      default: state_d = StRst;
    endcase
  end

endmodule

// File: tb/tb_risc_control_fsm.sv
module tb_risc_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;
  logic       irq = 1'b0;

  logic [1:0] nsel, vsel, mem_cmd;
  logic write, loada, loadb, loadc, loads, asel, bsel, load_ir, load_pc;
  logic reset_pc, load_vec, addr_sel, load_addr, halted, irq_ack;

  risc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op), .irq(irq),
    .nsel(nsel), .vsel(vsel), .write(write), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .load_ir(load_ir),
    .load_pc(load_pc), .reset_pc(reset_pc), .load_vec(load_vec), .addr_sel(addr_sel),
    .load_addr(load_addr), .mem_cmd(mem_cmd), .halted(halted), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] nsel;
    logic [1:0] vsel;
    logic write, loada, loadb, loadc, loads, asel, bsel, load_ir, load_pc;
    logic reset_pc, load_vec, addr_sel, load_addr;
    logic [1:0] mem_cmd;
    logic halted, irq_ack;
  } outs_t;

  typedef enum int {
    ERst, EIf1, EIf2, EUpd, EDec, EMovImm, EGetA, EGetB, EAluMov, EAluAdd, EAluCmp,
    EWriteRd, EAddrCalc, ELoadAddr, EMemRd, ELdrWb, EStrGetd, EStrPass, EMemWr, EHalt
  } exp_e;

  typedef struct {
    logic       rst;
    logic [2:0] opc;
    logic [1:0] op;
    exp_e       exp;
  } vec_t;

  vec_t       vecs[$];
  logic [2:0] cur_opc;
  logic [1:0] cur_op;
  int         checks = 0;
  int         passes = 0;
  outs_t      got;

  assign got = '{nsel: nsel, vsel: vsel, write: write, loada: loada, loadb: loadb,
                 loadc: loadc, loads: loads, asel: asel, bsel: bsel, load_ir: load_ir,
                 load_pc: load_pc, reset_pc: reset_pc, load_vec: load_vec,
                 addr_sel: addr_sel, load_addr: load_addr, mem_cmd: mem_cmd,
                 halted: halted, irq_ack: irq_ack};

  // Expected strobes for each step, written out from the state table.
  function automatic outs_t expect_of(input exp_e e);
    outs_t o;
    o = '0;
    case (e)
      ERst:      begin o.reset_pc = 1'b1; o.load_pc = 1'b1; end
      EIf1:      begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; end
      EIf2:      begin o.addr_sel = 1'b1; o.mem_cmd = 2'b01; o.load_ir = 1'b1; end
      EUpd:      o.load_pc = 1'b1;
      EDec:      o = '0;
      EMovImm:   begin o.nsel = 2'b00; o.vsel = 2'b01; o.write = 1'b1; end
      EGetA:     o.loada = 1'b1;
      EGetB:     begin o.nsel = 2'b10; o.loadb = 1'b1; end
      EAluMov:   begin o.asel = 1'b1; o.loadc = 1'b1; end
      EAluAdd:   o.loadc = 1'b1;
      EAluCmp:   o.loads = 1'b1;
      EWriteRd:  begin o.nsel = 2'b01; o.vsel = 2'b11; o.write = 1'b1; end
      EAddrCalc: begin o.bsel = 1'b1; o.loadc = 1'b1; end
      ELoadAddr: o.load_addr = 1'b1;
      EMemRd:    o.mem_cmd = 2'b01;
      ELdrWb:    begin o.mem_cmd = 2'b01; o.nsel = 2'b01; o.vsel = 2'b00; o.write = 1'b1; end
      EStrGetd:  begin o.nsel = 2'b01; o.loadb = 1'b1; end
      EStrPass:  begin o.asel = 1'b1; o.loadc = 1'b1; end
      EMemWr:    o.mem_cmd = 2'b10;
      EHalt:     o.halted = 1'b1;
      default:   o = '0;
    endcase
    return o;
  endfunction

  task automatic a(input exp_e e);
    vec_t v;
    v.rst = 1'b0;
    v.opc = cur_opc;
    v.op  = cur_op;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic ins(input logic [2:0] c, input logic [1:0] o);
    cur_opc = c;
    cur_op  = o;
  endtask

  // Drive inputs, clock once, and compare the outputs of the state just entered.
  task automatic step(input logic r, input logic [2:0] c, input logic [1:0] o,
                      input exp_e e, input string tag);
    outs_t want;
    reset  = r;
    opcode = c;
    op     = o;
    @(posedge clk);
    #1;
    want = expect_of(e);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got outputs %h, expected %h (%s)", tag, got, want, e.name());
  endtask

  initial begin
    vec_t v;
    v.rst = 1'b1; v.opc = 3'b000; v.op = 2'b00; v.exp = ERst;
    vecs.push_back(v);
    ins(3'b000, 2'b00); a(EIf1);
    ins(3'b110, 2'b10); a(EIf2); a(EUpd); a(EDec); a(EMovImm); a(EIf1);
    ins(3'b101, 2'b01); a(EIf2); a(EUpd); a(EDec); a(EGetA); a(EGetB); a(EAluCmp); a(EIf1);
    ins(3'b100, 2'b00); a(EIf2); a(EUpd); a(EDec); a(EGetA); a(EAddrCalc); a(ELoadAddr);
    a(EStrGetd); a(EStrPass); a(EMemWr); a(EIf1);
    ins(3'b101, 2'b00); a(EIf2); a(EUpd); a(EDec); a(EGetA); a(EGetB); a(EAluAdd);
    a(EWriteRd); a(EIf1);
    ins(3'b110, 2'b00); a(EIf2); a(EUpd); a(EDec); a(EGetB); a(EAluMov); a(EWriteRd); a(EIf1);
    ins(3'b000, 2'b11); a(EIf2); a(EUpd); a(EDec); a(EIf1);
    ins(3'b011, 2'b00); a(EIf2); a(EUpd); a(EDec); a(EGetA); a(EAddrCalc); a(ELoadAddr);
    a(EMemRd); a(ELdrWb); a(EIf1);
    ins(3'b111, 2'b01); a(EIf2); a(EUpd); a(EDec); a(EHalt);

    foreach (vecs[i]) step(vecs[i].rst, vecs[i].opc, vecs[i].op, vecs[i].exp,
                           $sformatf("vec%0d", i));

    // HALT holds regardless of inputs.
    for (int i = 0; i < 20; i++) step(1'b0, 3'(i), 2'(i), EHalt, "halt_hold");

    // Reset held two cycles from HALT, then released.
    step(1'b1, 3'b111, 2'b00, ERst, "rst_in_halt0");
    step(1'b1, 3'b111, 2'b00, ERst, "rst_in_halt1");
    step(1'b0, 3'b011, 2'b00, EIf1, "rst_release");

    // Reset in the middle of an LDR.
    step(1'b0, 3'b011, 2'b00, EIf2, "ldr2_if2");
    step(1'b0, 3'b011, 2'b00, EUpd, "ldr2_upd");
    step(1'b0, 3'b011, 2'b00, EDec, "ldr2_dec");
    step(1'b0, 3'b011, 2'b00, EGetA, "ldr2_geta");
    step(1'b1, 3'b011, 2'b00, ERst, "rst_mid_ldr");
    step(1'b0, 3'b011, 2'b00, EIf1, "mid_ldr_release");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
